index_decoder_scoreboard: RTL

Sequential counterpart to the priority encoder: converts binary indices into a persistent one-hot-per-index pending vector. Producers set bits by index, consumers clear bits by index, and the registered vector `wire_o` drives a `priority_encoder` downstream. Used as a busy/lock scoreboard (e.g. register or queue-slot tracking) with occupancy count and full/empty flags.

---
 rtl/index_decoder_scoreboard.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/index_decoder_scoreboard.sv
// Pending-entry scoreboard: producers set and consumers clear entries by binary index.
// Also holds the downstream lowest-index encoder and an invariant checker.
module index_decoder_scoreboard #(
  parameter int NUM_WIRE = 16,
  parameter int IW       = $clog2(NUM_WIRE),
  parameter int CW       = $clog2(NUM_WIRE + 1)
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic [IW-1:0]       set_index_i,
  input  logic                set_valid_i,
  output logic                set_ready_o,
  input  logic [IW-1:0]       clr_index_i,
  input  logic                clr_valid_i,
  output logic [NUM_WIRE-1:0] wire_o,
  output logic [CW-1:0]       count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                clr_err_o
);

  // Indices at or above NUM_WIRE decode to all zeros, so they can never touch state.
  function automatic logic [NUM_WIRE-1:0] decode_index(input logic [IW-1:0] index);
    logic [NUM_WIRE-1:0] onehot;
    onehot = {NUM_WIRE{1'b0}};
    for (int i = 0; i < NUM_WIRE; i++) begin
      onehot[i] = (index == IW'(i));
    end
    return onehot;
  endfunction

  logic [NUM_WIRE-1:0] wire_r, wire_nxt_s;
  logic [NUM_WIRE-1:0] set_onehot_s, clr_onehot_s;
  logic [CW-1:0]       count_r, count_nxt_s;
  logic                empty_r, full_r, clr_err_r;
  logic                empty_nxt_s, full_nxt_s, clr_err_nxt_s;
  logic                set_fire_s, clr_fire_s;

  // Decode requests and compute the next scoreboard state from the current vector.
  always_comb begin
    set_onehot_s  = decode_index(set_index_i);
    clr_onehot_s  = decode_index(clr_index_i);
    set_ready_o   = |(set_onehot_s & ~wire_r);
    set_fire_s    = set_valid_i & set_ready_o;
    clr_fire_s    = clr_valid_i & (|(clr_onehot_s & wire_r));
    clr_err_nxt_s = clr_valid_i & ~clr_fire_s;
    wire_nxt_s    = wire_r;
    if (set_fire_s) begin
      wire_nxt_s = wire_nxt_s | set_onehot_s;
    end else begin
      wire_nxt_s = wire_nxt_s;
    end
    if (clr_fire_s) begin
      wire_nxt_s = wire_nxt_s & ~clr_onehot_s;
    end else begin
      wire_nxt_s = wire_nxt_s;
    end
    case ({set_fire_s, clr_fire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == {CW{1'b0}}) begin
      empty_nxt_s = 1'b1;
    end else begin
      empty_nxt_s = 1'b0;
    end
    if (count_nxt_s == CW'(NUM_WIRE)) begin
      full_nxt_s = 1'b1;
    end else begin
      full_nxt_s = 1'b0;
    end
  end

  // Scoreboard state register; reset drops any request in flight.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wire_r    <= {NUM_WIRE{1'b0}};
      count_r   <= {CW{1'b0}};
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      clr_err_r <= 1'b0;
    end else begin
      wire_r    <= wire_nxt_s;
      count_r   <= count_nxt_s;
      empty_r   <= empty_nxt_s;
      full_r    <= full_nxt_s;
      clr_err_r <= clr_err_nxt_s;
    end
  end

  assign wire_o    = wire_r;
  assign count_o   = count_r;
  assign empty_o   = empty_r;
  assign full_o    = full_r;
  assign clr_err_o = clr_err_r;

endmodule

// Lowest set bit wins; consumes the scoreboard vector downstream.
module priority_encoder #(
  parameter int NUM_WIRE = 16,
  parameter int IW       = $clog2(NUM_WIRE)
) (
  input  logic [NUM_WIRE-1:0] wire_i,
  output logic [IW-1:0]       index_o,
  output logic                valid_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index_o = {IW{1'b0}};
    valid_o = |wire_i;
    for (int i = NUM_WIRE - 1; i >= 0; i--) begin
      index_o = wire_i[i] ? IW'(i) : index_o;
    end
  end

endmodule

// Structural invariants of the scoreboard outputs.
module index_decoder_scoreboard_chk #(
  parameter int NUM_WIRE = 16,
  parameter int CW       = $clog2(NUM_WIRE + 1)
) (
  input logic                clk_i,
  input logic                arst_ni,
  input logic [NUM_WIRE-1:0] wire_i,
  input logic [CW-1:0]       count_i,
  input logic                empty_i,
  input logic                full_i
);

  count_matches_pop: assert property (@(posedge clk_i) disable iff (!arst_ni)
    count_i == CW'($countones(wire_i)));
  empty_matches_count: assert property (@(posedge clk_i) disable iff (!arst_ni)
    empty_i == (count_i == {CW{1'b0}}));
  full_matches_count: assert property (@(posedge clk_i) disable iff (!arst_ni)
    full_i == (count_i == CW'(NUM_WIRE)));

endmodule
